// File: rtl/pe_rx_nic.sv
// PE-side ejection port: header check, good packets queued to the core; PE_RX_TIMESTAMP_EN adds out_ts.
// One-cycle accept-to-out_valid latency; pero is registered and drops the cycle after the FIFO fills.
module pe_rx_nic #(
    parameter int          PACKET_SIZE = 64,
    parameter logic [15:0] NODE_ID     = 16'h0000,
    parameter int          DEPTH       = 4,
    parameter int          CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   peso,
    input  logic [PACKET_SIZE-1:0] pedo,
    output logic                   pero,
    output logic                   out_valid,
    output logic [PACKET_SIZE-1:0] out_data,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       rx_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic                   err
`ifdef PE_RX_TIMESTAMP_EN
    ,
    output logic [31:0]            out_ts
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_FW = $clog2(DEPTH) + 1;
    localparam logic [CNT_FW-1:0] FULL = CNT_FW'(DEPTH);

    logic [PACKET_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]      count_q, count_d;
    logic                   pero_q, pero_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d, err_cnt_q, err_cnt_d;
    logic                   err_q, err_d;
    logic                   xfer, hdr_ok, push, drop, pop;
`ifdef PE_RX_TIMESTAMP_EN
    logic [31:0]            ts_mem_q [DEPTH];
    logic [31:0]            ts_q, ts_d;
`endif

    always_comb begin
        xfer   = peso && pero_q;
        // Hops are shifted right at every router, so an ejected packet must carry zero hops.
        hdr_ok = (pedo[15:0] == NODE_ID) && (pedo[39:36] == 4'h0) && (pedo[35:32] == 4'h0);
        push   = xfer && hdr_ok;
        drop   = xfer && !hdr_ok;
        pop    = (count_q != '0) && out_ready;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_FW'(1);
        else if (!push && pop)
            count_d = count_q - CNT_FW'(1);
        pero_d = (count_d < FULL);

        rx_cnt_d = rx_cnt_q;
        if (push && (rx_cnt_q != '1))
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
        err_cnt_d = err_cnt_q;
        if (drop && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + CNT_W'(1);
        err_d = err_q || drop;
`ifdef PE_RX_TIMESTAMP_EN
        ts_d = ts_q + 32'd1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pero_q    <= 1'b0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
`ifdef PE_RX_TIMESTAMP_EN
            ts_q      <= '0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pero_q    <= pero_d;
            rx_cnt_q  <= rx_cnt_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
`ifdef PE_RX_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]    <= pedo;
`ifdef PE_RX_TIMESTAMP_EN
            ts_mem_q[wr_ptr_q] <= ts_q;
`endif
        end
    end

    assign pero      = pero_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign rx_cnt    = rx_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err       = err_q;
`ifdef PE_RX_TIMESTAMP_EN
    assign out_ts    = ts_mem_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_pe_rx_nic.sv
// Bench for pe_rx_nic: directed scenarios then random traffic, checked against a queue-based model.
module tb_pe_rx_nic;
    localparam int          DEPTH = 4;
    localparam int          CNT_W = 4;
    localparam logic [15:0] NID   = 16'h000F;

    logic             clk, reset, peso, pero, out_valid, out_ready, err;
    logic [63:0]      pedo, out_data;
    logic [CNT_W-1:0] rx_cnt, err_cnt;
`ifdef PE_RX_TIMESTAMP_EN
    logic [31:0]      out_ts;
    logic [31:0]      cyc;
    logic [31:0]      tq[$];
`endif

    pe_rx_nic #(.PACKET_SIZE(64), .NODE_ID(NID), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .peso(peso), .pedo(pedo), .pero(pero),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .rx_cnt(rx_cnt), .err_cnt(err_cnt), .err(err)
`ifdef PE_RX_TIMESTAMP_EN
        , .out_ts(out_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PE_RX_TIMESTAMP_EN
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
`endif

    int               total = 0;
    int               bad = 0;
    logic [63:0]      q[$];
    logic             m_pero, m_err;
    int               m_rx, m_errc;
    bit               last_xfer;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pero"}, 64'(pero), 64'(m_pero));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".out_data"}, out_data, q[0]);
`ifdef PE_RX_TIMESTAMP_EN
            chk({tag, ".out_ts"}, 64'(out_ts), 64'(tq[0]));
`endif
        end
        chk({tag, ".rx_cnt"}, 64'(rx_cnt), 64'(m_rx));
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_errc));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
    endtask

    function automatic bit hdr_good(input logic [63:0] p);
        return (p[15:0] == NID) && (p[39:36] == 4'h0) && (p[35:32] == 4'h0);
    endfunction

    function automatic logic [63:0] mk(input bit ok);
        logic [63:0] p;
        p = {$urandom(), $urandom()};
        p[15:0]  = NID;
        p[39:32] = 8'h00;
        if (!ok) begin
            case ($urandom_range(0, 2))
                0:       p[15:0]  = NID ^ 16'($urandom_range(1, 65535));
                1:       p[39:36] = 4'($urandom_range(1, 15));
                default: p[35:32] = 4'($urandom_range(1, 15));
            endcase
        end
        return p;
    endfunction

    // One clock: predict from the rules, let the edge happen, then compare (called and returns at negedge).
    task automatic cycle(input string tag);
        bit xfer, good, pop;
        logic [63:0] p;
        xfer = peso && m_pero;
        p    = pedo;
        good = hdr_good(p);
        pop  = (q.size() != 0) && out_ready;
`ifdef PE_RX_TIMESTAMP_EN
        if (xfer && good) tq.push_back(cyc);
        if (pop) void'(tq.pop_front());
`endif
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (xfer && good) begin
            q.push_back(p);
            if (m_rx < (1 << CNT_W) - 1) m_rx++;
        end
        if (xfer && !good) begin
            if (m_errc < (1 << CNT_W) - 1) m_errc++;
            m_err = 1'b1;
        end
        m_pero    = (q.size() < DEPTH);
        last_xfer = xfer;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic send(input string tag, input logic [63:0] p, input int max_cyc);
        peso = 1'b1;
        pedo = p;
        last_xfer = 1'b0;
        for (int i = 0; i < max_cyc && !last_xfer; i++) cycle(tag);
        if (!last_xfer) begin
            total++;
            bad++;
            $error("FAIL %s.timeout observed=no_transfer expected=transfer", tag);
        end
        peso = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        q.delete();
`ifdef PE_RX_TIMESTAMP_EN
        tq.delete();
`endif
        m_pero = 1'b0;
        m_rx   = 0;
        m_errc = 0;
        m_err  = 1'b0;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] p0, p5;
        reset = 1'b1; peso = 1'b0; pedo = '0; out_ready = 1'b0;
        m_pero = 1'b0; m_rx = 0; m_errc = 0; m_err = 1'b0; last_xfer = 1'b0;
        @(negedge clk);
        do_reset("reset");
        cycle("rise");

        out_ready = 1'b1;
        p0 = {19'h0, 1'b0, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 16'h0000, 16'h000F};
        send("good0", p0, 4);
        chk("good0.head", out_data, p0);
        cycle("good0.pop");

        p5 = p0; p5[15:0] = 16'h000E;
        send("bad_dst", p5, 4);
        p5 = p0; p5[39:36] = 4'b0001;
        send("bad_hop", p5, 4);
        cycle("bad.idle");

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send("fill", mk(1'b1), 4);
        chk("full.pero", 64'(pero), 64'd0);
        p5 = mk(1'b1);
        peso = 1'b1; pedo = p5;
        for (int i = 0; i < 3; i++) begin
            cycle("held");
            chk("held.noxfer", 64'(last_xfer), 64'd0);
        end
        out_ready = 1'b1;
        send("fifth", p5, 6);
        for (int i = 0; i < 6; i++) cycle("drain");

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send("pre3", mk(1'b1), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) send("steady", mk(1'b1), 4);
        for (int i = 0; i < 5; i++) cycle("drain2");

        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) send("prerst", mk(1'b1), 4);
        peso = 1'b1; pedo = mk(1'b1);
        do_reset("midrst");
        cycle("rst.rise");
        chk("rst.pero_up", 64'(pero), 64'd1);
        out_ready = 1'b1;
        send("postrst", pedo, 4);
        cycle("postrst.pop");

        for (int i = 0; i < 18; i++) send("sat", mk(1'b0), 4);

        for (int i = 0; i < 400; i++) begin
            peso      = ($urandom_range(0, 3) != 0);
            pedo      = mk($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
